// File: rtl/bitonic_sort_iter_if.sv
// Handshake bundle for bitonic_sort_iter: input vector channel, sorted result
// channel and busy status.
interface bitonic_sort_iter_if #(
    parameter int N_LOG2      = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int LABEL_WIDTH = 1
);
    localparam int N = 1 << N_LOG2;

    logic                        x_valid;
    logic                        x_ready;
    logic [DATA_WIDTH*N-1:0]     x;
    logic [LABEL_WIDTH*N-1:0]    x_label;
    logic                        x_desc;
    logic [DATA_WIDTH*N-1:0]     y;
    logic [LABEL_WIDTH*N-1:0]    y_label;
    logic                        y_valid;
    logic                        y_ready;
    logic                        busy;

    modport master (
        output x_valid, x, x_label, x_desc, y_ready,
        input  x_ready, y, y_label, y_valid, busy
    );

    modport slave (
        input  x_valid, x, x_label, x_desc, y_ready,
        output x_ready, y, y_label, y_valid, busy
    );
endinterface

// File: rtl/bitonic_sort_iter.sv
// Iterative bitonic sorter: one bank of N/2 compare-exchange lanes is reused
// for every pass of the network, one pass per clock.

module bitonic_sort_cx #(
    parameter int DATA_WIDTH  = 8,
    parameter int LABEL_WIDTH = 1,
    parameter int SIGNED      = 0
) (
    input  logic [DATA_WIDTH-1:0]  a_key,
    input  logic [DATA_WIDTH-1:0]  b_key,
    input  logic [LABEL_WIDTH-1:0] a_lbl,
    input  logic [LABEL_WIDTH-1:0] b_lbl,
    input  logic                   asc,
    output logic [DATA_WIDTH-1:0]  oa_key,
    output logic [DATA_WIDTH-1:0]  ob_key,
    output logic [LABEL_WIDTH-1:0] oa_lbl,
    output logic [LABEL_WIDTH-1:0] ob_lbl
);
    logic a_gt_b, b_gt_a, swap;

    if (SIGNED != 0) begin : g_sgn
        assign a_gt_b = $signed(a_key) > $signed(b_key);
        assign b_gt_a = $signed(b_key) > $signed(a_key);
    end else begin : g_uns
        assign a_gt_b = a_key > b_key;
        assign b_gt_a = b_key > a_key;
    end

    // Strict compare: equal keys never swap.
    assign swap   = asc ? a_gt_b : b_gt_a;
    assign oa_key = swap ? b_key : a_key;
    assign ob_key = swap ? a_key : b_key;
    assign oa_lbl = swap ? b_lbl : a_lbl;
    assign ob_lbl = swap ? a_lbl : b_lbl;
endmodule

module bitonic_sort_iter #(
    parameter int N_LOG2      = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int LABEL_WIDTH = 1,
    parameter int SIGNED      = 0,
    parameter int ASCENDING   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    bitonic_sort_iter_if.slave   io
);
    localparam int N  = 1 << N_LOG2;
    localparam int NH = N / 2;
    localparam int P  = N_LOG2 * (N_LOG2 + 1) / 2;
    localparam int CW = $clog2(P + 1);
    localparam int SW = $clog2(N_LOG2 + 2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                              state;
    logic [CW-1:0]                       pass_cnt;
    logic [SW-1:0]                       stg, sub;
    logic                                eff_asc;
    logic                                y_vld_q, busy_q;
    logic [N-1:0][DATA_WIDTH-1:0]        wk_key, nx_key;
    logic [N-1:0][LABEL_WIDTH-1:0]       wk_lbl, nx_lbl;
    logic [NH-1:0][N_LOG2-1:0]           idx_a, idx_b;
    logic [NH-1:0]                       cx_asc;
    logic [NH-1:0][DATA_WIDTH-1:0]       oa_key, ob_key;
    logic [NH-1:0][LABEL_WIDTH-1:0]      oa_lbl, ob_lbl;
    logic                                accept;

    assign io.x_ready = !rst && (state == IDLE || (state == DONE && io.y_ready));
    assign accept     = io.x_valid && io.x_ready;
    assign io.y       = wk_key;
    assign io.y_label = wk_lbl;
    assign io.y_valid = y_vld_q;
    assign io.busy    = busy_q;

    // Lane u handles the u-th index with bit `sub` clear; its partner sets
    // that bit. Direction flips for blocks whose bit `stg` is set.
    always_comb begin
        idx_a  = '0;
        idx_b  = '0;
        cx_asc = '0;
        for (int u = 0; u < NH; u++) begin
            idx_a[u]  = N_LOG2'(((u >> sub) << (sub + 1'b1)) | (u & ((1 << sub) - 1)));
            idx_b[u]  = idx_a[u] | N_LOG2'(1 << sub);
            cx_asc[u] = (((32'(idx_a[u]) >> stg) & 1) != 0) ? ~eff_asc : eff_asc;
        end
    end

    for (genvar u = 0; u < NH; u++) begin : g_cx
        bitonic_sort_cx #(
            .DATA_WIDTH (DATA_WIDTH),
            .LABEL_WIDTH(LABEL_WIDTH),
            .SIGNED     (SIGNED)
        ) u_cx (
            .a_key (wk_key[idx_a[u]]),
            .b_key (wk_key[idx_b[u]]),
            .a_lbl (wk_lbl[idx_a[u]]),
            .b_lbl (wk_lbl[idx_b[u]]),
            .asc   (cx_asc[u]),
            .oa_key(oa_key[u]),
            .ob_key(ob_key[u]),
            .oa_lbl(oa_lbl[u]),
            .ob_lbl(ob_lbl[u])
        );
    end

    always_comb begin
        nx_key = wk_key;
        nx_lbl = wk_lbl;
        for (int u = 0; u < NH; u++) begin
            nx_key[idx_a[u]] = oa_key[u];
            nx_key[idx_b[u]] = ob_key[u];
            nx_lbl[idx_a[u]] = oa_lbl[u];
            nx_lbl[idx_b[u]] = ob_lbl[u];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pass_cnt <= '0;
            stg      <= '0;
            sub      <= '0;
            eff_asc  <= 1'b0;
            wk_key   <= '0;
            wk_lbl   <= '0;
            y_vld_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else if (accept) begin
            state    <= RUN;
            pass_cnt <= '0;
            stg      <= SW'(1);
            sub      <= '0;
            eff_asc  <= (ASCENDING != 0) ^ io.x_desc;
            wk_key   <= io.x;
            wk_lbl   <= io.x_label;
            y_vld_q  <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            case (state)
                RUN: begin
                    wk_key <= nx_key;
                    wk_lbl <= nx_lbl;
                    if (pass_cnt == CW'(P - 1)) begin
                        state   <= DONE;
                        y_vld_q <= 1'b1;
                    end else begin
                        pass_cnt <= pass_cnt + 1'b1;
                    end
                    // Walk stage s upward; substep j counts s-1 down to 0.
                    if (sub == '0) begin
                        stg <= stg + 1'b1;
                        sub <= stg;
                    end else begin
                        sub <= sub - 1'b1;
                    end
                end
                DONE: begin
                    if (io.y_ready) begin
                        state   <= IDLE;
                        y_vld_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bitonic_sort_iter.sv
// Randomized self-checking bench for bitonic_sort_iter: a sort-and-match model
// checks every result, plus directed literal cases.
module tb_bitonic_sort_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0;
    int n_acc = 0, n_out = 0;
    int prev_out = 0, last_out = 0;
    bit rnd_rdy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    bitonic_sort_iter_if #(.N_LOG2(3), .DATA_WIDTH(8), .LABEL_WIDTH(3)) bu ();
    bitonic_sort_iter_if #(.N_LOG2(3), .DATA_WIDTH(8), .LABEL_WIDTH(3)) bs ();

    bitonic_sort_iter #(.N_LOG2(3), .DATA_WIDTH(8), .LABEL_WIDTH(3), .SIGNED(0), .ASCENDING(1))
        u_dut (.clk(clk), .rst(rst), .io(bu.slave));
    bitonic_sort_iter #(.N_LOG2(3), .DATA_WIDTH(8), .LABEL_WIDTH(3), .SIGNED(1), .ASCENDING(1))
        s_dut (.clk(clk), .rst(rst), .io(bs.slave));

    typedef struct packed {
        logic [63:0] k;
        logic [23:0] l;
        logic        d;
        logic [31:0] acc;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack8(input int a[8]);
        logic [63:0] r = '0;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = 8'(a[i]);
        return r;
    endfunction

    function automatic logic [23:0] pack3(input int a[8]);
        logic [23:0] r = '0;
        for (int i = 0; i < 8; i++) r[3*i +: 3] = 3'(a[i]);
        return r;
    endfunction

    // Plain sort of the key values, reversed for descending order.
    function automatic logic [63:0] model_sort(input logic [63:0] k, input bit desc, input bit sgn);
        int a[8];
        int t;
        logic [63:0] r = '0;
        for (int i = 0; i < 8; i++)
            a[i] = sgn ? int'($signed(k[8*i +: 8])) : int'(k[8*i +: 8]);
        for (int p = 0; p < 8; p++)
            for (int i = 0; i < 7; i++)
                if (a[i] > a[i+1]) begin t = a[i]; a[i] = a[i+1]; a[i+1] = t; end
        for (int i = 0; i < 8; i++) r[8*i +: 8] = 8'(a[desc ? 7 - i : i]);
        return r;
    endfunction

    // Every output (key,label) pair must consume a distinct input pair.
    function automatic bit labels_ok(input logic [63:0] ik, input logic [23:0] il,
                                     input logic [63:0] ok, input logic [23:0] ol);
        bit used[8];
        bit found;
        for (int q = 0; q < 8; q++) used[q] = 0;
        for (int p = 0; p < 8; p++) begin
            found = 0;
            for (int q = 0; q < 8; q++)
                if (!found && !used[q] && ik[8*q +: 8] == ok[8*p +: 8] && il[3*q +: 3] == ol[3*p +: 3]) begin
                    used[q] = 1;
                    found = 1;
                end
            if (!found) return 0;
        end
        return 1;
    endfunction

    // Compare process for the unsigned instance.
    initial begin
        vec_t q[$];
        vec_t e;
        bit seen = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                seen = 0;
            end else begin
                if (bu.y_valid) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result actual_y=%h required=no_result", bu.y);
                    end else begin
                        if (!seen) begin
                            chk("latency", 64'(cyc - int'(q[0].acc)), 64'd7);
                            seen = 1;
                        end
                        chk("y_keys", bu.y, model_sort(q[0].k, q[0].d, 0));
                        chk("y_labels", 64'(labels_ok(q[0].k, q[0].l, bu.y, bu.y_label)), 64'd1);
                        chk("busy_in_done", 64'(bu.busy), 64'd1);
                        if (!bu.y_ready) chk("x_ready_stall", 64'(bu.x_ready), 64'd0);
                        else begin
                            q.delete(0);
                            seen = 0;
                            n_out++;
                            prev_out = last_out;
                            last_out = cyc;
                        end
                    end
                end else if (bu.busy) begin
                    chk("x_ready_run", 64'(bu.x_ready), 64'd0);
                end
                if (bu.x_valid && bu.x_ready) begin
                    e.k = bu.x; e.l = bu.x_label; e.d = bu.x_desc; e.acc = 32'(cyc);
                    q.push_back(e);
                    n_acc++;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_rdy) bu.y_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Present a vector and hold it until accepted; returns #1 after the accept edge.
    task automatic send(input logic [63:0] k, input logic [23:0] l, input bit d);
        int t = 0;
        bu.x = k; bu.x_label = l; bu.x_desc = d; bu.x_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bu.x_ready) break;
            if (++t > 100) begin chk("accept_timeout", 64'd0, 64'd1); break; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int t = 0;
        forever begin
            @(negedge clk);
            if (bu.y_valid) break;
            if (++t > 100) begin chk("valid_timeout", 64'd0, 64'd1); break; end
        end
    endtask

    task automatic wait_outs(input int target);
        int t = 0;
        while (n_out < target && t < 2000) begin @(negedge clk); t++; end
        chk("out_count", 64'(n_out), 64'(target));
    endtask

    function automatic logic [63:0] rnd_keys(input bit dup);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = dup ? 8'($urandom_range(0, 3)) : 8'($urandom);
        return r;
    endfunction

    // Signed instance: returns result and accept-to-valid negedge count.
    task automatic run_s(input logic [63:0] k, input logic [23:0] l, input bit d,
                         output logic [63:0] y, output logic [23:0] yl, output int lat);
        int t = 0;
        bs.x = k; bs.x_label = l; bs.x_desc = d; bs.x_valid = 1'b1;
        while (t < 100) begin @(negedge clk); if (bs.x_ready) break; t++; end
        @(posedge clk);
        #1;
        bs.x_valid = 1'b0;
        lat = 0;
        while (lat < 100) begin @(negedge clk); lat++; if (bs.y_valid) break; end
        y = bs.y;
        yl = bs.y_label;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ka[8] = '{5, 3, 7, 1, 6, 0, 4, 2};
        int ia[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
        int sa[8] = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h01, 8'hFE, 8'h10, 8'h90};
        logic [63:0] k, y0, sy;
        logic [23:0] l, l0, syl;
        int acc0, out0, lat;

        bu.x_valid = 0; bu.x = '0; bu.x_label = '0; bu.x_desc = 0; bu.y_ready = 1;
        bs.x_valid = 0; bs.x = '0; bs.x_label = '0; bs.x_desc = 0; bs.y_ready = 1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_y_valid", 64'(bu.y_valid), 64'd0);
        chk("rst_busy", 64'(bu.busy), 64'd0);
        chk("rst_x_ready", 64'(bu.x_ready), 64'd0);
        chk("rst_y", bu.y, 64'd0);
        chk("rst_y_label", 64'(bu.y_label), 64'd0);
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        chk("x_ready_after_rst", 64'(bu.x_ready), 64'd1);
        @(posedge clk); #1;

        // Directed ascending and descending vectors
        k = pack8(ka); l = pack3(ia);
        send(k, l, 0); bu.x_valid = 0;
        wait_valid();
        chk("lit_asc_y", bu.y, 64'h0706050403020100);
        chk("lit_asc_label", 64'(bu.y_label), 64'(pack3(ka)));
        @(posedge clk); #1;
        send(k, l, 1); bu.x_valid = 0;
        wait_valid();
        chk("lit_desc_y", bu.y, 64'h0001020304050607);
        @(posedge clk); #1;

        // Output stall with a second vector pending
        bu.y_ready = 0;
        send(rnd_keys(0), 24'($urandom), 0);
        bu.x = rnd_keys(1); bu.x_label = 24'($urandom); bu.x_desc = 1;
        wait_valid();
        y0 = bu.y; l0 = bu.y_label; acc0 = n_acc;
        repeat (10) begin
            @(negedge clk);
            chk("stall_y", bu.y, y0);
            chk("stall_label", 64'(bu.y_label), 64'(l0));
            chk("stall_valid", 64'(bu.y_valid), 64'd1);
            chk("stall_x_ready", 64'(bu.x_ready), 64'd0);
        end
        chk("stall_no_accept", 64'(n_acc), 64'(acc0));
        @(posedge clk); #1; bu.y_ready = 1;
        for (int t = 0; t < 20 && n_acc == acc0; t++) @(negedge clk);
        @(posedge clk); #1; bu.x_valid = 0;
        wait_outs(n_acc);
        @(posedge clk); #1;

        // Back-to-back stream of three vectors
        out0 = n_out;
        for (int v = 0; v < 3; v++) send(rnd_keys(v == 1), 24'($urandom), 1'(v == 2));
        bu.x_valid = 0;
        wait_outs(out0 + 3);
        chk("throughput", 64'(last_out - prev_out), 64'd7);
        @(posedge clk); #1;

        // Randomized traffic with random output backpressure
        rnd_rdy = 1;
        for (int v = 0; v < 40; v++) begin
            send(rnd_keys($urandom_range(0, 2) == 0), 24'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                bu.x_valid = 0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        bu.x_valid = 0;
        wait_outs(n_acc);
        rnd_rdy = 0;
        @(posedge clk); #1; bu.y_ready = 1;

        // Reset in the middle of a transaction
        out0 = n_out;
        send(rnd_keys(0), 24'($urandom), 0);
        bu.x_valid = 0;
        repeat (2) @(posedge clk);
        #1; rst = 1;
        @(posedge clk); #1;
        chk("midrst_y_valid", 64'(bu.y_valid), 64'd0);
        chk("midrst_busy", 64'(bu.busy), 64'd0);
        rst = 0;
        @(negedge clk);
        chk("midrst_x_ready", 64'(bu.x_ready), 64'd1);
        repeat (12) @(posedge clk);
        chk("midrst_no_stale", 64'(n_out), 64'(out0));
        #1;

        // Signed instance
        run_s(pack8(sa), pack3(ia), 0, sy, syl, lat);
        chk("lit_signed_y", sy, 64'h7F100100FFFE9080);
        chk("signed_latency", 64'(lat), 64'd7);
        for (int v = 0; v < 8; v++) begin
            k = rnd_keys(v[0]); l = 24'($urandom);
            run_s(k, l, 1'(v[1]), sy, syl, lat);
            chk("signed_y", sy, model_sort(k, v[1], 1));
            chk("signed_labels", 64'(labels_ok(k, l, sy, syl)), 64'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bitonic_sort_iter.md
BITONIC_SORT_ITER -- requirements
Module: bitonic_sort_iter

Interface
REQ-001 SHALL have parameter N_LOG2, default 3: log2 of element count N = 2^N_LOG2, legal range 1..6.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: key width per element.
REQ-003 SHALL have parameter LABEL_WIDTH, default 1: label width per element.
REQ-004 SHALL have parameter SIGNED, default 0: 1 = two's-complement key compare, 0 = unsigned.
REQ-005 SHALL have parameter ASCENDING, default 1: 1 = element 0 smallest, 0 = element 0 largest.
REQ-006 SHALL have one clock and a synchronous, active-high reset: clk  input  1  clock, rising edge; rst  input  1  reset.
REQ-007 SHALL have x_valid  input  1  input vector valid.
REQ-008 SHALL have x_ready  output  1  block can accept input.
REQ-009 SHALL have x  input  DATA_WIDTH*N  keys; element i at [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
REQ-010 SHALL have x_label  input  LABEL_WIDTH*N  labels, same packing as x.
REQ-011 SHALL have x_desc  input  1  per-vector direction invert, sampled on accept.
REQ-012 SHALL have y  output  DATA_WIDTH*N  sorted keys, same packing.
REQ-013 SHALL have y_label  output  LABEL_WIDTH*N  labels following their keys.
REQ-014 SHALL have y_valid  output  1  result valid.
REQ-015 SHALL have y_ready  input  1  downstream accepts result.
REQ-016 SHALL have busy  output  1  high in RUN or DONE.

Function
REQ-017 SHALL reuse a single bank of N/2 registered compare-exchange units over P = N_LOG2*(N_LOG2+1)/2 passes, one pass per clock.
REQ-018 SHALL implement FSM states IDLE, RUN, DONE.
REQ-019 SHALL assert x_ready only in IDLE, or in DONE while y_ready=1, and never while rst=1.
REQ-020 SHALL accept a vector on a rising edge with x_valid=1 and x_ready=1: load x, x_label and x_desc into the working register, clear the pass counter, enter RUN.
REQ-021 SHALL, in RUN, execute pass k (k=0..P-1) in stage/substep order s=1..N_LOG2, j=s-1 down to 0.
REQ-022 SHALL, in each pass, pair element i with element i+2^j for every i whose bit j is 0.
REQ-023 SHALL set the direction of each pair to the effective direction when bit s of i is 0 (or s=N_LOG2), and to its inverse otherwise.
REQ-024 SHALL define effective direction = ASCENDING XOR x_desc.
REQ-025 SHALL swap a pair only when strictly out of order; equal keys SHALL NOT swap.
REQ-026 SHALL move each label with its key.
REQ-027 SHALL enter DONE on the edge that completes pass P-1, so that y_valid rises exactly P edges after the accept edge (P=6 for N_LOG2=3).
REQ-028 SHALL hold y_valid, y and y_label stable in DONE until y_ready=1.
REQ-029 SHALL, on a DONE edge with y_ready=1: with x_valid=1, accept the new vector and enter RUN with no idle cycle; with x_valid=0, enter IDLE.
REQ-030 SHALL drive y and y_label directly from the working register; their contents are don't-care outside DONE.
REQ-031 SHALL ignore x, x_label and x_desc changes while in RUN.
REQ-032 SHALL size the pass counter to ceil(log2(P+1)) bits; the counter SHALL NOT wrap inside a transaction.

Reset
REQ-033 SHALL, on a rising edge with rst=1, force IDLE, clear the pass counter, and clear the working register, y, y_label, y_valid and busy to 0.
REQ-034 SHALL discard any in-flight RUN or DONE transaction on reset; no y_valid pulse SHALL follow it.
REQ-035 SHALL assert x_ready on the first cycle after rst deasserts.

Verification (N_LOG2=3, DATA_WIDTH=8, LABEL_WIDTH=3, SIGNED=0, ASCENDING=1 unless stated)
REQ-036 SHALL verify: x elements 0..7 = {5,3,7,1,6,0,4,2}, labels = index, x_desc=0 -> y_valid at accept+6 edges; y = {0,1,2,3,4,5,6,7}; y_label = {5,3,7,1,6,0,4,2}.
REQ-037 SHALL verify: same vector with x_desc=1 -> y = {7,6,5,4,3,2,1,0}.
REQ-038 SHALL verify: SIGNED=1, x = {0x80,0x7F,0xFF,0x00,0x01,0xFE,0x10,0x90} -> y = {0x80,0x90,0xFE,0xFF,0x00,0x01,0x10,0x7F}.
REQ-039 SHALL verify: y_ready held 0 for 10 cycles in DONE -> y, y_label and y_valid stable; x_ready=0 throughout; no second accept.
REQ-040 SHALL verify: y_ready=1 and x_valid=1 continuously over 3 vectors -> one result every 7 cycles, in input order.
REQ-041 SHALL verify: rst pulsed at pass 3 -> next cycle: state IDLE, y_valid=0, busy=0; x_ready=1 after rst falls; no stale result emitted.
